// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_pkg
// Description : Shared opcodes, command-word field positions, init table size
//               and FSM state encoding for the PLL command dispatcher.
// Revision    : 1.0  initial release
// ============================================================================
package pll_cfg_pkg;

    localparam logic [3:0] OP_WRITE  = 4'b0001;
    localparam logic [3:0] OP_STATUS = 4'b1000;

    localparam int OP_MSB  = 40;
    localparam int OP_LSB  = 37;
    localparam int CH_MSB  = 36;
    localparam int CH_LSB  = 32;
    localparam int REG_MSB = 31;
    localparam int REG_LSB = 0;

    localparam int INIT_WORDS = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_TAIL     = 3'd4,
        ST_LATCH    = 3'd5,
        ST_ACK      = 3'd6,
        ST_INIT     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_init_rom.sv
`default_nettype none
// ============================================================================
// Module      : pll_init_rom
// Description : Constant power-up register table indexed by {channel, entry}.
// Revision    : 1.0  initial release
// ============================================================================
module pll_init_rom (
    input  logic [4:0]  i_ch,
    input  logic [2:0]  i_entry,
    output logic [31:0] o_word
);

    logic [31:0] w_base;

    // Low three bits carry the register address, so the table keeps them clear.
    always_comb begin
        w_base = 32'h0000_0000;
        case (i_entry)
            3'd0:    w_base = 32'h0058_0000;
            3'd1:    w_base = 32'h0080_0008;
            3'd2:    w_base = 32'h0000_4E40;
            3'd3:    w_base = 32'h0600_8000;
            3'd4:    w_base = 32'h0800_0000;
            3'd5:    w_base = 32'h0032_0000;
            default: w_base = 32'h0000_0000;
        endcase
    end

    assign o_word = w_base | {11'd0, i_ch, 16'd0} | {29'd0, i_entry};

endmodule
`default_nettype wire

// File: rtl/pll_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : pll_cmd_dispatcher
// Description : Validates SPI command words and drives the shared 3-wire PLL
//               programming bus. Optional power-up table: PLL_INIT_SEQ_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pll_cmd_dispatcher #(
    parameter int CMD_BIT_NUM = 41,
    parameter int PLL_NUM     = 6,
    parameter int CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CMD_BIT_NUM-1:0] data,
    input  logic [6:0]             data_num,
    input  logic                   dready,
    output logic                   ack,
    output logic                   pll_sclk,
    output logic                   pll_sdata,
    output logic [PLL_NUM-1:0]     pll_le,
    output logic                   busy,
    output logic [7:0]             err_cnt,
    output logic [4:0]             last_ch
);

    import pll_cfg_pkg::*;

    localparam logic [PLL_NUM-1:0] c_LE_ONE  = {{(PLL_NUM-1){1'b0}}, 1'b1};
    localparam logic [4:0]         c_CH_LIM  = 5'(PLL_NUM);
    localparam logic [6:0]         c_NUM_OK  = 7'(CMD_BIT_NUM);
    localparam logic [7:0]         c_DIV_END = 8'(CLK_DIV - 1);

    state_t                 r_state;
    logic [CMD_BIT_NUM-1:0] r_cmd;
    logic [6:0]             r_num;
    logic [31:0]            r_shreg;
    logic [4:0]             r_bit;
    logic [7:0]             r_div;
    logic [4:0]             r_ch;
    logic                   r_ack;
    logic                   r_sclk;
    logic                   r_sdata;
    logic [PLL_NUM-1:0]     r_le;
    logic [7:0]             r_err;
    logic [4:0]             r_last_ch;

    logic [3:0]  w_op;
    logic [4:0]  w_cmd_ch;
    logic        w_div_done;
    logic        w_wr_ok;
    logic        w_start;
    logic [31:0] w_load_word;
    logic [4:0]  w_load_ch;
    logic [7:0]  w_err_inc;

    assign w_op       = r_cmd[OP_MSB:OP_LSB];
    assign w_cmd_ch   = r_cmd[CH_MSB:CH_LSB];
    assign w_div_done = (r_div == c_DIV_END);
    assign w_wr_ok    = (r_num == c_NUM_OK) && (w_op == OP_WRITE) && (w_cmd_ch < c_CH_LIM);
    assign w_err_inc  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

`ifdef PLL_INIT_SEQ_EN
    logic        r_init_busy;
    logic [4:0]  r_init_ch;
    logic [2:0]  r_init_ent;
    logic [31:0] w_rom_word;
    logic        w_init_last;

    pll_init_rom u_rom (
        .i_ch    (r_init_ch),
        .i_entry (r_init_ent),
        .o_word  (w_rom_word)
    );

    assign w_init_last = (r_init_ch == 5'(PLL_NUM - 1)) && (r_init_ent == 3'(INIT_WORDS - 1));
    assign w_start     = ((r_state == ST_CHECK) && w_wr_ok) || (r_state == ST_INIT);
    assign w_load_word = (r_state == ST_INIT) ? w_rom_word : r_cmd[REG_MSB:REG_LSB];
    assign w_load_ch   = (r_state == ST_INIT) ? r_init_ch  : w_cmd_ch;
`else
    assign w_start     = (r_state == ST_CHECK) && w_wr_ok;
    assign w_load_word = r_cmd[REG_MSB:REG_LSB];
    assign w_load_ch   = w_cmd_ch;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef PLL_INIT_SEQ_EN
            r_state     <= ST_INIT;
            r_init_busy <= 1'b1;
            r_init_ch   <= 5'd0;
            r_init_ent  <= 3'd0;
`else
            r_state     <= ST_IDLE;
`endif
            r_cmd     <= '0;
            r_num     <= 7'd0;
            r_shreg   <= 32'd0;
            r_bit     <= 5'd0;
            r_div     <= 8'd0;
            r_ch      <= 5'd0;
            r_ack     <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_le      <= '1;
            r_err     <= 8'd0;
            r_last_ch <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dready) begin
                        r_cmd   <= data;
                        r_num   <= data_num;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_wr_ok) begin
                        r_state <= ST_SHIFT_LO;
                    end else begin
                        if ((r_num != c_NUM_OK) || (w_op != OP_STATUS))
                            r_err <= w_err_inc;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_SHIFT_LO: begin
                    r_div <= r_div + 8'd1;
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_sclk  <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    r_div <= r_div + 8'd1;
                    if (w_div_done) begin
                        r_div  <= 8'd0;
                        r_sclk <= 1'b0;
                        if (r_bit == 5'd31) begin
                            r_state <= ST_TAIL;
                        end else begin
                            r_shreg <= {r_shreg[30:0], 1'b0};
                            r_sdata <= r_shreg[30];
                            r_bit   <= r_bit + 5'd1;
                            r_state <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_TAIL: begin
                    r_div <= r_div + 8'd1;
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_le    <= '1;
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_div <= r_div + 8'd1;
                    if (w_div_done) begin
                        r_div     <= 8'd0;
                        r_last_ch <= r_ch;
`ifdef PLL_INIT_SEQ_EN
                        if (r_init_busy) begin
                            if (w_init_last) begin
                                r_init_busy <= 1'b0;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_state <= ST_INIT;
                                if (r_init_ent == 3'(INIT_WORDS - 1)) begin
                                    r_init_ent <= 3'd0;
                                    r_init_ch  <= r_init_ch + 5'd1;
                                end else begin
                                    r_init_ent <= r_init_ent + 3'd1;
                                end
                            end
                        end else begin
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end
`else
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
`endif
                    end
                end
                ST_ACK: begin
                    if (!dready) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`ifdef PLL_INIT_SEQ_EN
                ST_INIT: r_state <= ST_SHIFT_LO;
`endif
                default: r_state <= ST_IDLE;
            endcase

            // Frame start shared by host writes and the power-up table.
            if (w_start) begin
                r_shreg <= w_load_word;
                r_sdata <= w_load_word[31];
                r_le    <= ~(c_LE_ONE << w_load_ch);
                r_ch    <= w_load_ch;
                r_sclk  <= 1'b0;
                r_bit   <= 5'd0;
                r_div   <= 8'd0;
            end
        end
    end

    assign ack       = r_ack;
    assign pll_sclk  = r_sclk;
    assign pll_sdata = r_sdata;
    assign pll_le    = r_le;
    assign busy      = (r_state != ST_IDLE);
    assign err_cnt   = r_err;
    assign last_ch   = r_last_ch;

endmodule
`default_nettype wire

// File: tb/tb_pll_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_cmd_dispatcher
// Description : Randomized self-checking bench for pll_cmd_dispatcher.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_cmd_dispatcher;

    localparam int CMD_BIT_NUM = 41;
    localparam int PLL_NUM     = 6;
    localparam int CLK_DIV     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CMD_BIT_NUM-1:0] data;
    logic [6:0]             data_num;
    logic                   dready;
    logic                   ack;
    logic                   pll_sclk;
    logic                   pll_sdata;
    logic [PLL_NUM-1:0]     pll_le;
    logic                   busy;
    logic [7:0]             err_cnt;
    logic [4:0]             last_ch;

    pll_cmd_dispatcher #(
        .CMD_BIT_NUM (CMD_BIT_NUM),
        .PLL_NUM     (PLL_NUM),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_num  (data_num),
        .dready    (dready),
        .ack       (ack),
        .pll_sclk  (pll_sclk),
        .pll_sdata (pll_sdata),
        .pll_le    (pll_le),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .last_ch   (last_ch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_err  = 0;
    int exp_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus observer: counts frames, sclk rises, LE-low cycles and protocol slips.
    int unsigned        m_rises = 0, m_low_cyc = 0, m_frames = 0, m_multi = 0, m_bad = 0;
    int                 m_low_ch = -1;
    logic [31:0]        m_bits = 32'd0;
    logic               p_sclk = 1'b0, p_sdata = 1'b0;
    logic [PLL_NUM-1:0] p_le = '1;

    always @(negedge clk) begin
        if (pll_le != '1) begin
            m_low_cyc++;
            if ($countones(~pll_le) != 1) m_multi++;
        end
        if (p_le == '1 && pll_le != '1) begin
            m_frames++;
            for (int i = 0; i < PLL_NUM; i++) if (!pll_le[i]) m_low_ch = i;
        end
        if (!p_sclk && pll_sclk) begin
            m_rises++;
            m_bits = {m_bits[30:0], pll_sdata};
        end
        if (p_le != '1 && pll_le != '1 && pll_sdata != p_sdata && !(p_sclk && !pll_sclk)) m_bad++;
        if (pll_le == '1 && pll_sclk) m_bad++;
        p_sclk  = pll_sclk;
        p_sdata = pll_sdata;
        p_le    = pll_le;
    end

    task automatic run_cmd(input logic [3:0] op, input logic [4:0] ch, input logic [31:0] word,
                           input logic [6:0] num, input int hold, input bit full);
        int unsigned f0, r0, l0, mu0, b0;
        int  lat, ackhi;
        bit  is_wr, is_st;
        is_wr = (num == 7'd41) && (op == 4'b0001) && (ch < PLL_NUM);
        is_st = (num == 7'd41) && (op == 4'b1000);
        f0 = m_frames; r0 = m_rises; l0 = m_low_cyc; mu0 = m_multi; b0 = m_bad;
        @(negedge clk);
        data = {op, ch, word}; data_num = num; dready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!ack && lat < 2000);
        chk("ack_seen", ack, 1);
        if (!is_wr && !is_st) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        if (is_wr) exp_last = ch;
        if (full) begin
            chk("latency", lat, is_wr ? 2 + 66 * CLK_DIV : 2);
            chk("frames", m_frames - f0, is_wr ? 1 : 0);
            if (is_wr) begin
                chk("sclk_rises", m_rises - r0, 32);
                chk("bits", m_bits, word);
                chk("le_low_cyc", m_low_cyc - l0, 65 * CLK_DIV);
                chk("le_chan", m_low_ch, ch);
            end
            chk("one_le", m_multi - mu0, 0);
            chk("bus_proto", m_bad - b0, 0);
            chk("err_cnt", err_cnt, exp_err);
            chk("last_ch", last_ch, exp_last);
            chk("busy_ack", busy, 1);
        end
        ackhi = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ack) ackhi++;
        end
        if (full && hold > 0) chk("ack_hold", ackhi, hold);
        dready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (ack && lat < 10);
        if (full) begin
            chk("ack_drop", ack, 0);
            chk("idle", busy, 0);
            chk("single_frame", m_frames - f0, is_wr ? 1 : 0);
        end
    endtask

    initial begin
        int unsigned f0;
        int          w;
        rst = 1'b1; dready = 1'b0; data = '0; data_num = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_sclk", pll_sclk, 0);
        chk("rst_sdata", pll_sdata, 0);
        chk("rst_le", pll_le, 6'h3F);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_last", last_ch, 0);
        rst = 1'b0;
`ifdef PLL_INIT_SEQ_EN
        f0 = m_frames;
        w  = 0;
        while (busy && w < 20000) begin @(negedge clk); w++; end
        chk("init_done", busy, 0);
        chk("init_frames", m_frames - f0, PLL_NUM * 6);
        exp_last = PLL_NUM - 1;
`endif

        run_cmd(4'b0001, 5'd2, 32'hA5A5_0F0F, 7'd41, 0, 1);
        run_cmd(4'b0001, 5'd1, 32'h1234_5678, 7'd40, 0, 1);
        run_cmd(4'b0001, 5'd7, 32'hDEAD_BEEF, 7'd41, 0, 1);
        run_cmd(4'b0001, 5'd6, 32'hDEAD_BEEF, 7'd41, 0, 1);
        run_cmd(4'b1000, 5'd0, 32'h0000_0000, 7'd41, 0, 1);
        run_cmd(4'b0001, 5'd5, 32'h8000_0001, 7'd41, 20, 1);
        run_cmd(4'b0010, 5'd0, 32'hFFFF_FFFF, 7'd41, 0, 1);

        // Reset in the middle of a frame, between clock edges.
        f0 = m_rises;
        @(negedge clk);
        data = {4'b0001, 5'd3, 32'hCAFE_F00D}; data_num = 7'd41; dready = 1'b1;
        w = 0;
        while (m_rises - f0 < 10 && w < 2000) begin @(negedge clk); w++; end
        chk("mid_frame", m_rises - f0, 10);
        #2 rst = 1'b1;
        #1;
        chk("arst_le", pll_le, 6'h3F);
        chk("arst_sclk", pll_sclk, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_cnt, 0);
        exp_err = 0; exp_last = 0; dready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`ifdef PLL_INIT_SEQ_EN
        w = 0;
        while (busy && w < 20000) begin @(negedge clk); w++; end
        exp_last = PLL_NUM - 1;
`endif
        run_cmd(4'b0001, 5'd0, 32'h0F1E_2D3C, 7'd41, 0, 1);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            logic [6:0] num;
            case ($urandom_range(0, 3))
                0, 1:    op = 4'b0001;
                2:       op = 4'b1000;
                default: op = 4'($urandom_range(0, 15));
            endcase
            num = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd41;
            run_cmd(op, 5'($urandom_range(0, 7)), $urandom, num, $urandom_range(0, 3), 1);
        end

        for (int n = 0; n < 300; n++)
            run_cmd(4'b1111, 5'($urandom_range(0, 31)), $urandom, 7'd41, 0, 0);
        chk("err_sat", err_cnt, 255);
        chk("err_sat_model", err_cnt, exp_err);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_cmd_dispatcher.md
Name: pll_cmd_dispatcher

Overview:
- Consumes complete command words from the SPI slave front end (data/data_num/dready/ack handshake).
- Validates and decodes each word, then sequences a shared 3-wire serial register write (sclk/sdata/per-channel LE) to one of PLL_NUM synthesizer chips.
- Sits between the SPI slave and the PLL chips. It is the only driver of the shared PLL programming bus.

Parameters:
- CMD_BIT_NUM, 41, command word width: [40:37] opcode, [36:32] channel, [31:0] PLL register word
- PLL_NUM, 6, number of PLL chips (LE lines)
- CLK_DIV, 4, clk cycles per serial clock phase (high or low); legal range 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data  in  CMD_BIT_NUM  received command word, bit 0 = last bit shifted in
- data_num  in  7  number of bits received in the frame
- dready  in  1  command word valid
- ack  out  1  command consumed
- pll_sclk  out  1  shared serial clock
- pll_sdata  out  1  shared serial data, MSB first
- pll_le  out  PLL_NUM  per-chip latch enable; idle high, low during the frame, rising edge latches
- busy  out  1  high whenever state != IDLE
- err_cnt  out  8  count of rejected commands, saturating at 255
- last_ch  out  5  channel of the last completed write

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: ack=0, pll_sclk=0, pll_sdata=0, pll_le=all 1, busy=0, err_cnt=0, last_ch=0, state=IDLE.
- Reset mid-frame: LE returns high immediately (asynchronously). The partial word is never latched by any chip.
- States: IDLE, CHECK, SHIFT_LO, SHIFT_HI, TAIL, LATCH, ACK.
- IDLE:
  - On a clk edge where dready=1: capture data and data_num, go to CHECK.
  - dready is ignored in every other state; the word simply waits.
- CHECK (1 cycle):
  - data_num != CMD_BIT_NUM -> err_cnt+1, go to ACK.
  - Else opcode 4'b0001 and channel < PLL_NUM -> load the 32-bit shift register, assert pll_le[channel]=0, set sclk=0 and sdata=word[31], bit counter=0, go to SHIFT_LO.
  - Else opcode 4'b1000 (status read, answered by the SPI slave) -> go to ACK with no error.
  - Any other opcode, or channel >= PLL_NUM -> err_cnt+1, go to ACK.
- SHIFT_LO: hold CLK_DIV cycles with sclk=0, then go to SHIFT_HI with sclk=1.
- SHIFT_HI:
  - Hold CLK_DIV cycles.
  - If bit counter = 31: go to TAIL with sclk=0.
  - Else: shift, present the next bit on sdata, counter+1, sclk=0, go to SHIFT_LO.
  - sdata changes only on sclk falling transitions; the chip samples on rising.
- TAIL: hold CLK_DIV cycles with sclk=0, then drive LE high and go to LATCH.
- LATCH: hold CLK_DIV cycles with all LE high (minimum LE-high time), update last_ch, go to ACK.
- Frame timing: LE-low time is exactly 65*CLK_DIV cycles; sclk rising edges are exactly 32.
- ACK (four-phase handshake):
  - ack=1 while in this state.
  - Stay until dready is sampled 0, then drop ack and go to IDLE.
  - Consequence: a given word is never processed twice.
- Latency: ack rises 2 cycles after dready is sampled for rejected/read commands, and 2+66*CLK_DIV cycles after it for writes.
- err_cnt holds at 255.
- Only one LE line is ever low at a time.

Optional Feature:
- Macro: PLL_INIT_SEQ_EN.
- When defined:
  - After reset, state INIT runs first with busy=1 and dready not serviced.
  - INIT writes a constant default table (INIT_WORDS entries per channel, channel 0 first, entries in ascending index order) using the same SHIFT/TAIL/LATCH path.
  - Then go to IDLE.
  - A reset during INIT restarts the table from entry 0.
- When undefined: the block enters IDLE directly after reset and no table logic exists.

Decomposition:
- Shared package pll_cfg_pkg holds:
  - opcode constants OP_WRITE=4'b0001 and OP_STATUS=4'b1000
  - field bit positions for opcode, channel and register word
  - INIT_WORDS, set to 6
  - the state encoding
- One natural sub-module, pll_init_rom: combinational table indexed by {channel, entry}. It is instantiated only under PLL_INIT_SEQ_EN.

Test Plan:
- Write: data={4'b0001,5'd2,32'hA5A5_0F0F}, data_num=41, dready=1 until ack, CLK_DIV=4 -> only pll_le[2] low for 260 cycles; 32 sclk rises; sampled bits = A5A50F0F MSB first; ack after; last_ch=2.
- Short frame: data_num=40 with a valid write -> no LE activity, err_cnt=1, ack asserted.
- Bad channel: channel=7 with PLL_NUM=6 -> err_cnt increments, no LE activity. Opcode 4'b1000 -> ack only, err_cnt unchanged.
- Handshake: hold dready high 20 cycles after ack -> ack stays high for those 20 cycles; exactly one frame is issued.
- Async reset: assert rst at bit 10 of a frame -> all LE high and sclk 0 without waiting for a clk edge; the next command executes normally.
- Saturation: 300 bad commands -> err_cnt=255. With PLL_INIT_SEQ_EN: 36 frames after reset before the first ack.
